// File: rtl/msk_tof_pkg.sv
// Shared constants and helpers for the masked Toffoli gadget: randomness budget
// per lane and the location of each share pair's r/s bits inside a lane slice.
package msk_tof_pkg;

  localparam int R_OFS         = 0;
  localparam int S_OFS         = 1;
  localparam int BITS_PER_PAIR = 2;

  function automatic int rnd_per_lane(input int d);
    return d * (d - 1);
  endfunction

  // Lexicographic index of the unordered pair (i, j), i < j.
  function automatic int pair_idx(input int i, input int j, input int d);
    return (i * (2 * d - i - 1)) / 2 + (j - i - 1);
  endfunction

  // Bit position of r_ij or s_ij in a lane slice; symmetric in i and j.
  function automatic int rnd_bit(input int i, input int j, input int d, input int ofs);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return BITS_PER_PAIR * pair_idx(lo, hi, d) + ofs;
  endfunction

endpackage

// File: rtl/msk_tof_hpc3_lane.sv
// One lane of the d-share HPC3-style Toffoli gadget: registers the diagonal,
// product and refresh terms on en, then XORs registered terms per share.
module msk_tof_hpc3_lane
  import msk_tof_pkg::*;
#(
  parameter int D = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [D-1:0]               x,
  input  logic [D-1:0]               y,
  input  logic [D-1:0]               c,
  input  logic [rnd_per_lane(D)-1:0] rnd,
  output logic [D-1:0]               out
);

  logic [D-1:0]        d_d, d_q;
  logic [D-1:0][D-1:0] p_d, p_q;
  logic [D-1:0][D-1:0] q_d, q_q;

  always_comb begin
    // NOTE: every target gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    d_d = d_q;
    p_d = p_q;
    q_d = q_q;
    if (en) begin
      for (int i = 0; i < D; i++) begin
        d_d[i] = (x[i] & y[i]) ^ c[i];
        for (int j = 0; j < D; j++) begin
          if (j == i) begin
            p_d[i][j] = 1'b0;
            q_d[i][j] = 1'b0;
          end else begin
            // Only y_j masked by r_ij crosses into domain i before the register.
            p_d[i][j] = x[i] & (y[j] ^ rnd[rnd_bit(i, j, D, R_OFS)]);
            q_d[i][j] = (~x[i] & rnd[rnd_bit(i, j, D, R_OFS)]) ^ rnd[rnd_bit(i, j, D, S_OFS)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: share registers are cleared on reset so no stale share survives a restart; sequential state uses <= only.
    if (rst) begin
      d_q <= '0;
      p_q <= '0;
      q_q <= '0;
    end else begin
      d_q <= d_d;
      p_q <= p_d;
      q_q <= q_d;
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < D; i++) begin
      out[i] = d_q[i];
      for (int j = 0; j < D; j++) begin
        if (j != i) out[i] = out[i] ^ p_q[i][j] ^ q_q[i][j];
      end
    end
  end

endmodule

// File: rtl/msk_tof_hpc3_pipe.sv
// Multi-lane masked Toffoli stage, out = a*b ^ c per lane, with operand swap,
// one register stage, valid/ready handshake and a saturating transaction count.
module msk_tof_hpc3_pipe
  import msk_tof_pkg::*;
#(
  parameter int D  = 2,
  parameter int L  = 1,
  parameter int CW = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         swap,
  input  logic [L*D-1:0]               ina,
  input  logic [L*D-1:0]               inb,
  input  logic [L*D-1:0]               inc,
  input  logic [L*rnd_per_lane(D)-1:0] rnd,
  input  logic                         rnd_valid,
  output logic [L*D-1:0]               out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CW-1:0]                n_ops
);

  localparam int RND = rnd_per_lane(D);

  logic           fire;
  logic           out_valid_d, out_valid_q;
  logic [CW-1:0]  n_ops_d, n_ops_q;
  logic [L*D-1:0] x, y;

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    fire        = in_valid && rnd_valid && in_ready;
    out_valid_d = out_valid_q;
    if (fire)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    n_ops_d = n_ops_q;
    if (fire && (n_ops_q != '1)) n_ops_d = n_ops_q + CW'(1);
    x = swap ? inb : ina;
    y = swap ? ina : inb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      n_ops_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      n_ops_q     <= n_ops_d;
    end
  end

  // Term registers only load on fire, so a stalled result is held as-is.
  for (genvar k = 0; k < L; k++) begin : g_lane
    msk_tof_hpc3_lane #(.D(D)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (fire),
      .x   (x[k*D +: D]),
      .y   (y[k*D +: D]),
      .c   (inc[k*D +: D]),
      .rnd (rnd[k*RND +: RND]),
      .out (out[k*D +: D])
    );
  end

  assign out_valid = out_valid_q;
  assign n_ops     = n_ops_q;

endmodule

// File: tb/tb_msk_tof_hpc3_pipe.sv
// Bench for msk_tof_hpc3_pipe: a D=2/L=2/CW=4 instance and a D=3/L=1/CW=16
// instance checked against a share-level algebraic model and the unshared a*b^c.
module tb_msk_tof_hpc3_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic       iv2, rv2, ordy2, sw2, irdy2, ov2;
  logic [3:0] a2, b2, c2, r2, o2, n2;

  logic        iv3, rv3, ordy3, sw3, irdy3, ov3;
  logic [2:0]  a3, b3, c3, o3;
  logic [5:0]  r3;
  logic [15:0] n3;

  logic       m2_v;
  logic [3:0] m2_o;
  int         m2_n;
  logic       m3_v;
  logic [2:0] m3_o;
  int         m3_n;

  msk_tof_hpc3_pipe #(.D(2), .L(2), .CW(4)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(irdy2), .swap(sw2),
    .ina(a2), .inb(b2), .inc(c2), .rnd(r2), .rnd_valid(rv2),
    .out(o2), .out_valid(ov2), .out_ready(ordy2), .n_ops(n2)
  );

  msk_tof_hpc3_pipe #(.D(3), .L(1), .CW(16)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(irdy3), .swap(sw3),
    .ina(a3), .inb(b3), .inc(c3), .rnd(r3), .rnd_valid(rv3),
    .out(o3), .out_valid(ov3), .out_ready(ordy3), .n_ops(n3)
  );

  // Position of pair (lo, hi) found by walking all pairs in lexicographic order.
  function automatic int pair_number(input int lo, input int hi, input int d);
    int n = 0;
    for (int u = 0; u < d; u++) begin
      for (int v = u + 1; v < d; v++) begin
        if (u == lo && v == hi) return n;
        n++;
      end
    end
    return -1;
  endfunction

  // out_i = x_i*y_i ^ c_i ^ XOR_{j!=i}(x_i*y_j ^ r_ij ^ s_ij)
  function automatic logic [7:0] model(input int d, input int l, input logic sw,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [15:0] r);
    logic [7:0] o;
    int         rp;
    o  = '0;
    rp = d * (d - 1);
    for (int k = 0; k < l; k++) begin
      for (int i = 0; i < d; i++) begin
        logic xi, yi, yj, acc;
        int   pn;
        xi  = sw ? b[k*d+i] : a[k*d+i];
        yi  = sw ? a[k*d+i] : b[k*d+i];
        acc = (xi & yi) ^ c[k*d+i];
        for (int j = 0; j < d; j++) begin
          if (j != i) begin
            yj  = sw ? a[k*d+j] : b[k*d+j];
            pn  = (i < j) ? pair_number(i, j, d) : pair_number(j, i, d);
            acc = acc ^ (xi & yj) ^ r[k*rp + 2*pn] ^ r[k*rp + 2*pn + 1];
          end
        end
        o[k*d+i] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic lane_xor(input logic [7:0] v, input int d, input int k);
    logic p = 1'b0;
    for (int i = 0; i < d; i++) p = p ^ v[k*d+i];
    return p;
  endfunction

  function automatic logic unshared(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] c, input int d, input int k);
    return (lane_xor(a, d, k) & lane_xor(b, d, k)) ^ lane_xor(c, d, k);
  endfunction

  // One clock on the D=2 instance: drive at negedge, update model at posedge, return at next negedge.
  task automatic step2(input logic rs, input logic iv, input logic rv, input logic ordy,
                       input logic sw, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] r);
    logic f;
    rst = rs; iv2 = iv; rv2 = rv; ordy2 = ordy; sw2 = sw;
    a2 = a; b2 = b; c2 = c; r2 = r;
    f = iv && rv && (!m2_v || ordy);
    @(posedge clk);
    if (rs) begin
      m2_v = 1'b0; m2_o = '0; m2_n = 0;
    end else if (f) begin
      m2_o = 4'(model(2, 2, sw, 8'(a), 8'(b), 8'(c), 16'(r)));
      m2_v = 1'b1;
      if (m2_n < 15) m2_n++;
    end else if (ordy) begin
      m2_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic step3(input logic rs, input logic iv, input logic rv, input logic ordy,
                       input logic sw, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [5:0] r);
    logic f;
    rst = rs; iv3 = iv; rv3 = rv; ordy3 = ordy; sw3 = sw;
    a3 = a; b3 = b; c3 = c; r3 = r;
    f = iv && rv && (!m3_v || ordy);
    @(posedge clk);
    if (rs) begin
      m3_v = 1'b0; m3_o = '0; m3_n = 0;
    end else if (f) begin
      m3_o = 3'(model(3, 1, sw, 8'(a), 8'(b), 8'(c), 16'(r)));
      m3_v = 1'b1;
      if (m3_n < 65535) m3_n++;
    end else if (ordy) begin
      m3_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    iv3 = 1'b1; rv3 = 1'b1; ordy3 = 1'b1;
    step2(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h3);
    step2(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 4'h6, 4'hC);
    iv3 = 1'b0;
    total++; if (o2 !== 4'h0) begin bad++; $display("FAIL reset_out2 got=%h exp=0", o2); end
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%b exp=0", ov2); end
    total++; if (n2 !== 4'h0) begin bad++; $display("FAIL reset_nops2 got=%0d exp=0", n2); end
    total++; if (irdy2 !== 1'b1) begin bad++; $display("FAIL reset_ready2 got=%b exp=1", irdy2); end
    total++; if (o3 !== 3'h0) begin bad++; $display("FAIL reset_out3 got=%h exp=0", o3); end
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL reset_valid3 got=%b exp=0", ov3); end
    total++; if (n3 !== 16'h0) begin bad++; $display("FAIL reset_nops3 got=%0d exp=0", n3); end
  endtask

  task automatic test_basic();
    step2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    // lane0: a=(1,0) b=(1,1) c=(0,1), r=1 s=0
    step2(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0011, 4'b0010, 4'b0001);
    total++; if ((^o2[1:0]) !== 1'b1) begin bad++; $display("FAIL basic_xor got=%b exp=1", ^o2[1:0]); end
    total++; if (o2 !== m2_o) begin bad++; $display("FAIL basic_shares got=%h exp=%h", o2, m2_o); end
    total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", ov2); end
    total++; if (n2 !== 4'd1) begin bad++; $display("FAIL basic_nops got=%0d exp=1", n2); end
    step2(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0011, 4'b0010, 4'b0010);
    total++; if ((^o2[1:0]) !== 1'b1) begin bad++; $display("FAIL swap_xor got=%b exp=1", ^o2[1:0]); end
    total++; if (o2 !== m2_o) begin bad++; $display("FAIL swap_shares got=%h exp=%h", o2, m2_o); end
    total++; if (n2 !== 4'd2) begin bad++; $display("FAIL swap_nops got=%0d exp=2", n2); end
  endtask

  task automatic test_sweep_d2();
    step2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      logic [3:0] a, b, c, r;
      vv = 9'(v);
      a  = {2'($urandom), vv[1:0]};
      b  = {2'($urandom), vv[3:2]};
      c  = {2'($urandom), vv[5:4]};
      r  = {2'($urandom), vv[7:6]};
      step2(1'b0, 1'b1, 1'b1, 1'b1, vv[8], a, b, c, r);
      total++; if (o2 !== m2_o) begin bad++; $display("FAIL sweep2_shares v=%0d got=%h exp=%h", v, o2, m2_o); end
      total++; if ((^o2[1:0]) !== unshared(8'(a), 8'(b), 8'(c), 2, 0))
        begin bad++; $display("FAIL sweep2_lane0 v=%0d got=%b", v, ^o2[1:0]); end
      total++; if ((^o2[3:2]) !== unshared(8'(a), 8'(b), 8'(c), 2, 1))
        begin bad++; $display("FAIL sweep2_lane1 v=%0d got=%b", v, ^o2[3:2]); end
    end
  endtask

  task automatic test_sweep_d3();
    step3(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'h0, 3'h0, 3'h0, 6'h0);
    for (int v = 0; v < 32768; v++) begin
      logic [14:0] vv;
      vv = 15'(v);
      step3(1'b0, 1'b1, 1'b1, 1'b1, 1'($urandom), vv[2:0], vv[5:3], vv[8:6], vv[14:9]);
      total++; if (o3 !== m3_o) begin bad++; $display("FAIL sweep3_shares v=%0d got=%h exp=%h", v, o3, m3_o); end
      total++; if ((^o3) !== unshared(8'(vv[2:0]), 8'(vv[5:3]), 8'(vv[8:6]), 3, 0))
        begin bad++; $display("FAIL sweep3_xor v=%0d got=%b", v, ^o3); end
    end
    total++; if (n3 !== 16'd32768) begin bad++; $display("FAIL sweep3_nops got=%0d exp=32768", n3); end
  endtask

  task automatic test_stall();
    logic [3:0] held;
    step2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    step2(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 4'h7, 4'h5, 4'h6);
    held = m2_o;
    for (int i = 0; i < 5; i++) begin
      step2(1'b0, 1'b1, 1'b1, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      total++; if (o2 !== held) begin bad++; $display("FAIL stall_hold i=%0d got=%h exp=%h", i, o2, held); end
      total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL stall_valid i=%0d got=%b exp=1", i, ov2); end
      total++; if (irdy2 !== 1'b0) begin bad++; $display("FAIL stall_ready i=%0d got=%b exp=0", i, irdy2); end
      total++; if (n2 !== 4'd1) begin bad++; $display("FAIL stall_nops i=%0d got=%0d exp=1", i, n2); end
    end
    ordy2 = 1'b1;
    #1;
    total++; if (irdy2 !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", irdy2); end
    step2(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 4'hE, 4'h8, 4'h9);
    total++; if (o2 !== m2_o) begin bad++; $display("FAIL stall_next got=%h exp=%h", o2, m2_o); end
    total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL stall_nobubble got=%b exp=1", ov2); end
    total++; if (n2 !== 4'd2) begin bad++; $display("FAIL stall_next_nops got=%0d exp=2", n2); end
  endtask

  task automatic test_rnd_gate();
    logic exp_v [3] = '{1'b1, 1'b0, 1'b1};
    logic rv_seq [3] = '{1'b1, 1'b0, 1'b1};
    step2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rndgate_valid0 got=%b exp=0", ov2); end
    for (int i = 0; i < 3; i++) begin
      step2(1'b0, 1'b1, rv_seq[i], 1'b1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      total++; if (ov2 !== exp_v[i]) begin bad++; $display("FAIL rndgate_valid i=%0d got=%b exp=%b", i, ov2, exp_v[i]); end
      total++; if (o2 !== m2_o) begin bad++; $display("FAIL rndgate_out i=%0d got=%h exp=%h", i, o2, m2_o); end
      total++; if (irdy2 !== 1'b1) begin bad++; $display("FAIL rndgate_ready i=%0d got=%b exp=1", i, irdy2); end
    end
    total++; if (n2 !== 4'd2) begin bad++; $display("FAIL rndgate_nops got=%0d exp=2", n2); end
  endtask

  task automatic test_saturate();
    step2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      int e;
      e = (i + 1 > 15) ? 15 : i + 1;
      step2(1'b0, 1'b1, 1'b1, 1'b1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      total++; if (n2 !== 4'(e)) begin bad++; $display("FAIL sat_nops i=%0d got=%0d exp=%0d", i, n2, e); end
      total++; if (o2 !== m2_o) begin bad++; $display("FAIL sat_out i=%0d got=%h exp=%h", i, o2, m2_o); end
    end
  endtask

  task automatic test_reset_stall();
    step2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    step2(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hA, 4'h5);
    step2(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL rststall_pre_valid got=%b exp=1", ov2); end
    // Reset together with a would-be fire.
    step2(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'h5, 4'hA);
    ordy2 = 1'b0;
    #1;
    total++; if (o2 !== 4'h0) begin bad++; $display("FAIL rststall_out got=%h exp=0", o2); end
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rststall_valid got=%b exp=0", ov2); end
    total++; if (n2 !== 4'h0) begin bad++; $display("FAIL rststall_nops got=%0d exp=0", n2); end
    total++; if (irdy2 !== 1'b1) begin bad++; $display("FAIL rststall_ready got=%b exp=1", irdy2); end
    step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rststall_dropped got=%b exp=0", ov2); end
    total++; if (n2 !== 4'h0) begin bad++; $display("FAIL rststall_dropped_nops got=%0d exp=0", n2); end
    total++; if (o2 !== 4'h0) begin bad++; $display("FAIL rststall_dropped_out got=%h exp=0", o2); end
  endtask

  initial begin
    rst = 1'b1;
    iv2 = 1'b0; rv2 = 1'b0; ordy2 = 1'b0; sw2 = 1'b0;
    a2 = '0; b2 = '0; c2 = '0; r2 = '0;
    iv3 = 1'b0; rv3 = 1'b0; ordy3 = 1'b0; sw3 = 1'b0;
    a3 = '0; b3 = '0; c3 = '0; r3 = '0;
    m2_v = 1'b0; m2_o = '0; m2_n = 0;
    m3_v = 1'b0; m3_o = '0; m3_n = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_sweep_d2();
    test_stall();
    test_rnd_gate();
    test_saturate();
    test_reset_stall();
    test_sweep_d3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
